// File: rtl/ram_stream_reader.sv
// Streams a contiguous block of RAM words to a ready/valid output through a small skid FIFO.
// Optional macro RAM_STREAM_READER_WRAP_EN lets a block run past the top address and wrap to 0.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_len_i,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] remain_reg;
  logic [RD_LATENCY-1:0] pipe_vld_reg;
  logic [RD_LATENCY-1:0] pipe_last_reg;
  logic [DATA_WIDTH:0]   buf_mem [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic                  err_reg;

  logic [CW-1:0]         inflight;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  bad_cmd;
  logic [DATA_WIDTH:0]   head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CW'(pipe_vld_reg[i]);
    end
  end

  // Reads still in the RAM pipeline reserve their FIFO slot, so the buffer can never overflow.
  assign issue = (state_reg == S_READ) && ((inflight + count_reg) < CW'(BUF_DEPTH));
  assign push  = pipe_vld_reg[RD_LATENCY-1];
  assign pop   = m_valid_o && m_ready_i;

`ifdef RAM_STREAM_READER_WRAP_EN
  assign bad_cmd = 1'b0;
  assign err_o   = 1'b0;
`else
  logic [ADDR_WIDTH:0] end_sum;
  assign end_sum = {1'b0, cmd_addr_i} + {1'b0, cmd_len_i};
  assign bad_cmd = end_sum[ADDR_WIDTH];
  assign err_o   = err_reg;
`endif

  assign head        = buf_mem[rd_ptr_reg];
  assign m_valid_o   = (count_reg != '0);
  assign m_data_o    = m_valid_o ? head[DATA_WIDTH-1:0] : '0;
  assign m_last_o    = m_valid_o && head[DATA_WIDTH];
  assign cmd_ready_o = (state_reg == S_IDLE);
  assign busy_o      = (state_reg != S_IDLE);
  assign ram_addr_o  = addr_reg;

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_mem[wr_ptr_reg] <= {pipe_last_reg[RD_LATENCY-1], ram_data_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      remain_reg    <= '0;
      pipe_vld_reg  <= '0;
      pipe_last_reg <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      pipe_vld_reg[0]  <= issue;
      pipe_last_reg[0] <= issue && (remain_reg == '0);
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_reg[i]  <= pipe_vld_reg[i-1];
        pipe_last_reg[i] <= pipe_last_reg[i-1];
      end

      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (!push && pop) count_reg <= count_reg - 1'b1;

      err_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (cmd_valid_i) begin
            if (bad_cmd) begin
              err_reg <= 1'b1;
            end else begin
              addr_reg   <= cmd_addr_i;
              remain_reg <= cmd_len_i;
              state_reg  <= S_READ;
            end
          end
        end
        S_READ: begin
          if (issue) begin
            addr_reg   <= addr_reg + 1'b1;
            remain_reg <= remain_reg - 1'b1;
            if (remain_reg == '0) state_reg <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && m_last_o) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench: drives one command stream into two readers (RAM latency 1 and 2) and checks each
// against an address-sequence model of the expected beats.
module tb_ram_stream_reader;

`ifdef RAM_STREAM_READER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i;
  logic       cmd_valid;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_len;
  logic       m_ready;

  logic [7:0] ram_addr [2];
  logic [7:0] ram_data [2];
  logic [7:0] m_data [2];
  logic       m_valid [2];
  logic       m_last [2];
  logic       cmd_ready [2];
  logic       busy [2];
  logic       err [2];

  logic [7:0] mem [256];
  logic [7:0] exp_data [256];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int exp_n = 0;
  int mode = 0;
  int rx_cnt [2];
  bit seen [2];
  bit mon_en = 1'b0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] len;
    int         rmode;
    bit         exp_err;
  } vec_t;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      logic [7:0] r1 = 8'h00;
      logic [7:0] r2 = 8'h00;
      bit         hold = 1'b0;
      logic [7:0] hold_data = 8'h00;

      ram_stream_reader #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8), .RD_LATENCY(gi + 1), .BUF_DEPTH(4)
      ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready[gi]),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .ram_addr_o(ram_addr[gi]), .ram_data_i(ram_data[gi]),
        .m_data_o(m_data[gi]), .m_valid_o(m_valid[gi]), .m_last_o(m_last[gi]),
        .m_ready_i(m_ready), .busy_o(busy[gi]), .err_o(err[gi])
      );

      // Synchronous RAM: one register, plus an output register for the latency-2 instance.
      always @(posedge clk) begin
        r1 <= mem[ram_addr[gi]];
        r2 <= r1;
      end
      assign ram_data[gi] = (gi == 0) ? r1 : r2;

      always @(negedge clk) begin
        if (mon_en && !rst_i) begin
          if (hold) begin
            chk("hold_valid", int'(m_valid[gi]), 1);
            chk("hold_data", int'(m_data[gi]), int'(hold_data));
          end
          if (m_valid[gi]) begin
            if (!seen[gi]) begin
              seen[gi] = 1'b1;
              chk("first_valid_lat", cyc - hs_cyc, gi + 2);
            end
            if (m_ready) begin
              if (rx_cnt[gi] >= exp_n) begin
                chk("beat_count", rx_cnt[gi] + 1, exp_n);
              end else begin
                chk("beat_data", int'(m_data[gi]), int'(exp_data[rx_cnt[gi]]));
                chk("beat_last", int'(m_last[gi]), int'(rx_cnt[gi] == exp_n - 1));
              end
              rx_cnt[gi]++;
            end
          end
          hold = m_valid[gi] && !m_ready;
          hold_data = m_data[gi];
        end else begin
          hold = 1'b0;
        end
      end
    end
  endgenerate

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ready pattern: 0 always, 1 toggling, 2 random, 3 held low for 20 cycles after the handshake.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = cyc[0];
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = (cyc >= hs_cyc + 20);
      endcase
    end
  end

  task automatic check_reset();
    for (int i = 0; i < 2; i++) begin
      chk("rst_cmd_ready", int'(cmd_ready[i]), 1);
      chk("rst_m_valid", int'(m_valid[i]), 0);
      chk("rst_m_last", int'(m_last[i]), 0);
      chk("rst_m_data", int'(m_data[i]), 0);
      chk("rst_ram_addr", int'(ram_addr[i]), 0);
      chk("rst_busy", int'(busy[i]), 0);
      chk("rst_err", int'(err[i]), 0);
    end
  endtask

  task automatic start_cmd(input logic [7:0] addr, input logic [7:0] len, input int m,
                           input bit e);
    int k;
    exp_n = e ? 0 : int'(len) + 1;
    for (int i = 0; i < exp_n; i++) exp_data[i] = mem[8'(int'(addr) + i)];
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!(cmd_ready[0] && cmd_ready[1]) && k < 1000);
    chk("cmd_ready_wait", int'(cmd_ready[0] && cmd_ready[1]), 1);
    rx_cnt[0] = 0;
    rx_cnt[1] = 0;
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    mode = m;
    cmd_addr = addr;
    cmd_len = len;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    hs_cyc = cyc;
    if (e) begin
      for (int i = 0; i < 2; i++) begin
        chk("err_pulse", int'(err[i]), 1);
        chk("err_busy", int'(busy[i]), 0);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) chk("err_clear", int'(err[i]), 0);
      repeat (8) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) chk("err_idle", int'(busy[i]), 0);
    end
    if (m == 3) begin
      repeat (18) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) chk("stall_addr", int'(ram_addr[i]), int'(8'(addr + 8'd4)));
    end
  endtask

  task automatic finish_cmd();
    int k;
    k = 0;
    while (!(rx_cnt[0] == exp_n && rx_cnt[1] == exp_n && !busy[0] && !busy[1]) && k < 600) begin
      @(posedge clk);
      #1;
      k++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rx_count", rx_cnt[i], exp_n);
      chk("end_ready", int'(cmd_ready[i]), 1);
      chk("end_busy", int'(busy[i]), 0);
    end
  endtask

  vec_t vecs [8];

  initial begin
    int k;
    logic [7:0] a;
    logic [7:0] l;
    vecs[0] = '{8'h10, 8'd3,  0, 1'b0};
    vecs[1] = '{8'h10, 8'd3,  1, 1'b0};
    vecs[2] = '{8'h40, 8'd15, 3, 1'b0};
    vecs[3] = '{8'hFE, 8'd3,  0, !WRAP};
    vecs[4] = '{8'hFF, 8'd0,  0, 1'b0};
    vecs[5] = '{8'h00, 8'd0,  1, 1'b0};
    vecs[6] = '{8'hF0, 8'd15, 2, 1'b0};
    vecs[7] = '{8'hF1, 8'd15, 0, !WRAP};

    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    rst_i = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = 8'h00;
    cmd_len = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst_i = 1'b0;
    mon_en = 1'b1;

    for (int v = 0; v < 8; v++) begin
      start_cmd(vecs[v].addr, vecs[v].len, vecs[v].rmode, vecs[v].exp_err);
      finish_cmd();
    end

    // Abort mid-command after two beats, then a single-beat command must come out clean.
    start_cmd(8'h30, 8'd7, 0, 1'b0);
    k = 0;
    while (rx_cnt[0] < 2 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("abort_point", rx_cnt[0], 2);
    mon_en = 1'b0;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check_reset();
    mon_en = 1'b1;
    start_cmd(8'h20, 8'd0, 0, 1'b0);
    finish_cmd();

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int r = 0; r < 12; r++) begin
      a = 8'($urandom_range(0, 255));
      l = 8'($urandom_range(0, 20));
      start_cmd(a, l, $urandom_range(0, 2), !WRAP && (int'(a) + int'(l) > 255));
      finish_cmd();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
